// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants and state encoding for the UART receive frame sequencer.
package uart_rx_pkg;

  localparam int DATA_W   = 8;
  localparam int PRESC_W  = 6;
  localparam int STRB_OFS = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Strobes are registered, so they are armed one edge before Prescale-STRB_OFS.
  function automatic logic [PRESC_W-1:0] strb_pre(input logic [PRESC_W-1:0] presc);
    return presc - PRESC_W'(STRB_OFS + 1);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Strobe/result handshake between the frame sequencer and the start/data/parity/stop checkers.
interface uart_rx_ctrl_if;
  logic deser_en;
  logic strt_chk_en;
  logic par_chk_en;
  logic stp_chk_en;
  logic strt_glitch;
  logic par_err;
  logic stp_err;

  modport master (
    output deser_en, strt_chk_en, par_chk_en, stp_chk_en,
    input  strt_glitch, par_err, stp_err
  );

  modport slave (
    input  deser_en, strt_chk_en, par_chk_en, stp_chk_en,
    output strt_glitch, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and data-bit counter; wraps at the latched Prescale-1.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cnt_en_i,
  input  logic               bit_inc_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic [3:0]         bit_cnt_o,
  output logic               bit_end_o,
  output logic               last_bit_o
);

  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [3:0]         bit_q, bit_d;

  always_comb begin
    bit_end_o  = cnt_en_i && (edge_q == presc_i - PRESC_W'(1));
    last_bit_o = (bit_q == 4'(DATA_W - 1));
    edge_d     = '0;
    if (cnt_en_i && !bit_end_o) edge_d = edge_q + PRESC_W'(1);
    bit_d = bit_q;
    if (bit_inc_i && bit_end_o) bit_d = last_bit_o ? 4'd0 : bit_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detection, bit timing, checker strobes and data_valid.
module uart_rx_ctrl
  import uart_rx_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  output logic               dat_samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               data_valid,
  uart_rx_ctrl_if.master     chk
);

  rx_state_e          state_q, state_d;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q, frame_err_q;
  logic               samp_q, strt_q, deser_q, par_q, stp_q, dv_q;
  logic               bit_end, last_bit, strb_arm;

  uart_rx_edge_bit_cnt u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .cnt_en_i   (state_q != IDLE),
    .bit_inc_i  (state_q == DATA),
    .presc_i    (presc_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_end_o  (bit_end),
    .last_bit_o (last_bit)
  );

  assign strb_arm = (edge_cnt == strb_pre(presc_q));

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!RX_IN) state_d = START;
      START:   if (bit_end) state_d = chk.strt_glitch ? IDLE : DATA;
      DATA:    if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      par_en_q    <= 1'b0;
      frame_err_q <= 1'b0;
      samp_q      <= 1'b0;
      strt_q      <= 1'b0;
      deser_q     <= 1'b0;
      par_q       <= 1'b0;
      stp_q       <= 1'b0;
      dv_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= (state_d != IDLE);
      // The arm point never coincides with bit end, so the current state is the strobe's state.
      strt_q  <= (state_q == START)  && strb_arm;
      deser_q <= (state_q == DATA)   && strb_arm;
      par_q   <= (state_q == PARITY) && strb_arm;
      stp_q   <= (state_q == STOP)   && strb_arm;
      dv_q    <= (state_q == STOP) && bit_end && !chk.stp_err && !(par_en_q && frame_err_q);
      if (state_q == IDLE && !RX_IN) begin
        presc_q     <= Prescale;
        par_en_q    <= PAR_EN;
        frame_err_q <= 1'b0;
      end
      if (state_q == PARITY && bit_end) frame_err_q <= chk.par_err;
    end
  end

  assign dat_samp_en     = samp_q;
  assign data_valid      = dv_q;
  assign chk.strt_chk_en = strt_q;
  assign chk.deser_en    = deser_q;
  assign chk.par_chk_en  = par_q;
  assign chk.stp_chk_en  = stp_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame sequencer for the UART receiver. It detects the start condition on the serial line and runs the oversampling edge counter and the bit counter. It issues one-cycle enables to the data sampler, deserializer, start/parity/stop checkers, and raises data_valid for error-free frames. It sits between the raw RX line and the receive datapath sub-blocks. All checkers register their error flag one cycle after their enable.

Parameters:
DATA_W, 8, data bits per frame (LSB first)
PRESC_W, 6, width of Prescale and edge_cnt (supported Prescale values: 8, 16, 32)

Ports:
CLK  in  1  RX oversampling clock
RST  in  1  synchronous, active-high reset
RX_IN  in  1  serial line, idle high
PAR_EN  in  1  parity bit present
Prescale  in  PRESC_W  clocks per bit
strt_glitch  in  1  start checker result (registered)
par_err  in  1  parity checker result (registered)
stp_err  in  1  stop checker result (registered)
dat_samp_en  out  1  sampler enable
edge_cnt  out  PRESC_W  position inside current bit, 0..Prescale-1
bit_cnt  out  4  data bit index, 0..DATA_W-1
deser_en  out  1  deserializer shift strobe
strt_chk_en  out  1  start check strobe
par_chk_en  out  1  parity check strobe
stp_chk_en  out  1  stop check strobe
data_valid  out  1  frame accepted pulse

Behaviour:
- Reset: RST high at a CLK edge forces state IDLE, edge_cnt=0, bit_cnt=0, and all outputs 0. RST overrides everything, including mid-frame; no partial data_valid is produced.
- States: IDLE, START, DATA, PARITY, STOP; registered state with Moore-style strobes decoded from state and edge_cnt.
- IDLE: RX_IN==0 sampled → START next cycle, with edge_cnt=0 and bit_cnt=0. PAR_EN and Prescale are latched at this transition and held for the frame.
- edge_cnt increments every cycle outside IDLE. At Prescale-1 ("bit end") it wraps to 0. In IDLE it is held at 0.
- dat_samp_en=1 in every state except IDLE.
- Strobe rule: the state's strobe is high for exactly one cycle, at edge_cnt==Prescale-2. The checker flag is evaluated by the FSM at bit end (edge_cnt==Prescale-1).
  - START: strobe is strt_chk_en.
  - DATA: strobe is deser_en.
  - PARITY: strobe is par_chk_en.
  - STOP: strobe is stp_chk_en.
- START at bit end: strt_glitch=1 → IDLE (frame aborted, no data_valid); otherwise → DATA.
- DATA at bit end:
  - bit_cnt increments.
  - If bit_cnt==DATA_W-1: → PARITY if latched PAR_EN, else → STOP. bit_cnt returns to 0.
- PARITY at bit end: → STOP regardless of par_err. par_err is captured internally into a frame-error flag.
- STOP at bit end: → IDLE. data_valid asserts for one cycle on the next clock iff stp_err==0 and (latched PAR_EN==0 or captured par_err==0).
- Back-to-back frames: a start bit present on the cycle after STOP's bit end is detected from IDLE (at most one cycle of start-bit position lost; within the sampling margin).
- Changes on PAR_EN or Prescale mid-frame are ignored until the next IDLE→START transition.
- Frame length in cycles = Prescale × (1 + DATA_W + PAR_EN + 1).

Decomposition:
- Package uart_rx_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, 3-bit binary);
  - DATA_W;
  - PRESC_W;
  - a constant for the strobe offset (Prescale-2).
- One sub-module, uart_rx_edge_bit_cnt. It holds edge_cnt and bit_cnt with enable, wrap at latched Prescale-1, and bit increment controlled by the FSM. It also produces the bit-end flag.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0xA5 with stop bit=1. RX_IN falls at cycle 0 → START at cycle 1. Eight deser_en pulses follow, at cycles 15, 23, …, 71; stp_chk_en at cycle 79; data_valid=1 only at cycle 81.
2. Prescale=8, PAR_EN=1, frame 0x3C with correct parity → par_chk_en at cycle 79, stp_chk_en at cycle 87, data_valid pulse at cycle 89. With par_err forced to 1: same timing, data_valid stays 0.
3. Stop error: stp_err=1 at stop bit end → no data_valid; FSM returns to IDLE and correctly accepts an immediately following 0x55 frame.
4. Start glitch: RX_IN low for 2 cycles then high, with strt_glitch=1 at cycle 8 → return to IDLE at cycle 9. No deser_en and no data_valid.
5. Prescale=16 and Prescale=32 with frame 0xFF → strobe spacing 16/32 cycles; data_valid at cycle 161/321. Changing Prescale mid-frame has no effect.
6. RST asserted during DATA at bit_cnt=4 → next cycle IDLE, edge_cnt=0, bit_cnt=0, all strobes 0. A new frame afterwards completes normally.
